// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer
// Purpose  : Pops words from a first-word-fall-through buffer and sends each
//            one as a valid/ready byte stream with a last-byte marker.
// Revision : 1.0 - initial release
// ============================================================================
module word_serializer #(
    parameter int DATA_WIDTH = 35,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic                  next_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    localparam int NB = (DATA_WIDTH + 7) / 8;
    localparam int SW = NB * 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [SW-1:0]        word_q,  word_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

    logic          w_accept;
    logic          w_final;
    logic          w_pop;
    logic [IW-1:0] w_sel;
    logic [SW-1:0] w_shift;

    assign w_accept = (state_q == S_SEND) && out_ready;
    assign w_final  = w_accept && (idx_q == LAST_IDX);
    // Gated by reset so the pop strobe reads 0 while reset is held.
    assign w_pop    = reset && !buf_empty && ((state_q == S_IDLE) || w_final);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (w_final) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (w_pop) begin
            word_d                 = '0;
            word_d[DATA_WIDTH-1:0] = buf_data;
            idx_d                  = '0;
            state_d                = S_SEND;
        end else if (w_final) begin
            idx_d   = '0;
            state_d = S_IDLE;
        end else if (w_accept) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_sel   = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    assign w_shift = word_q >> {w_sel, 3'b000};

    assign next_ready = w_pop;
    assign out_valid  = (state_q == S_SEND);
    assign busy       = (state_q == S_SEND);
    assign out_byte   = out_valid ? w_shift[7:0] : 8'h00;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign words_sent = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_serializer
// Purpose  : Directed vector table plus randomized scoreboard run for
//            word_serializer (LSB-first and MSB-first instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        buf_empty = 1'b1;
    logic [34:0] buf_data = '0;
    logic        out_ready = 1'b1;

    logic        nr0, vld0, last0, busy0;
    logic [7:0]  byte0;
    logic [15:0] ws0;
    logic        nr1, vld1, last1, busy1;
    logic [7:0]  byte1;
    logic [2:0]  ws1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    word_serializer #(.DATA_WIDTH(35), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) u_lsb (
        .clk(clk), .reset(reset), .buf_empty(buf_empty), .buf_data(buf_data),
        .next_ready(nr0), .out_valid(vld0), .out_ready(out_ready),
        .out_byte(byte0), .out_last(last0), .busy(busy0), .words_sent(ws0));

    word_serializer #(.DATA_WIDTH(35), .MSB_FIRST(1'b1), .CNT_WIDTH(3)) u_msb (
        .clk(clk), .reset(reset), .buf_empty(buf_empty), .buf_data(buf_data),
        .next_ready(nr1), .out_valid(vld1), .out_ready(out_ready),
        .out_byte(byte1), .out_last(last1), .busy(busy1), .words_sent(ws1));

    typedef struct {
        bit          dut;
        bit          rs;
        logic        empty;
        logic [34:0] data;
        logic        rdy;
        logic        nr;
        logic        vld;
        logic [7:0]  byt;
        logic        last;
        logic [15:0] ws;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit d, bit rs, logic e, logic [34:0] dat, logic r,
                                logic nr, logic v, logic [7:0] b, logic l, logic [15:0] w);
        vec_t x;
        x.dut = d; x.rs = rs; x.empty = e; x.data = dat; x.rdy = r;
        x.nr = nr; x.vld = v; x.byt = b; x.last = l; x.ws = w;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        buf_empty = 1'b1;
        buf_data  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Bytes of a word in transmit order, bit 8 = last-byte marker.
    function automatic void push_word(ref logic [8:0] q[$], input logic [34:0] w, input bit msb);
        logic [39:0] wx;
        wx = {5'b0, w};
        for (int k = 0; k < 5; k++) begin
            int s;
            s = msb ? (4 - k) : k;
            q.push_back({(k == 4), wx[s*8 +: 8]});
        end
    endfunction

    logic [34:0] bufq[$];
    logic [8:0]  expq0[$];
    logic [8:0]  expq1[$];

    initial begin
        int mws0, mws1;
        logic enr;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 10; i++) add(0, i == 0, 1, 0, 1, 0, 0, 8'h00, 0, 0);

        add(0, 1, 0, 35'h5_DEAD_BEEF, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'hEF, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'hBE, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'hAD, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'hDE, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'h05, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1);

        add(0, 1, 0, 35'h1, 1, 1, 0, 8'h00, 0, 0);
        for (int w = 1; w <= 3; w++)
            for (int b = 0; b < 5; b++)
                add(0, 0, (w == 3), 35'(w + 1), 1, (b == 4) && (w < 3), 1,
                    (b == 0) ? 8'(w) : 8'h00, (b == 4), 16'(w - 1));
        add(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 3);

        add(0, 1, 0, 35'h7_0000_0001, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'h01, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 0, 0, 35'hAB, 0, 0, 1, 8'h07, 1, 0);
        add(0, 0, 0, 35'hAB, 1, 1, 1, 8'h07, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 8'hAB, 0, 1);
        for (int b = 1; b < 5; b++) add(0, 0, 1, 0, 1, 0, 1, 8'h00, (b == 4), 1);
        add(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 2);

        add(1, 1, 0, 35'h4_1234_5678, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 8'h04, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 8'h12, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 8'h34, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 8'h56, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 8'h78, 1, 0);
        add(1, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            buf_empty = tbl[i].empty;
            buf_data  = tbl[i].data;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            if (tbl[i].dut) begin
                chk($sformatf("tbl%0d.next_ready", i), 32'(nr1), 32'(tbl[i].nr));
                chk($sformatf("tbl%0d.out_valid", i), 32'(vld1), 32'(tbl[i].vld));
                chk($sformatf("tbl%0d.busy", i), 32'(busy1), 32'(tbl[i].vld));
                chk($sformatf("tbl%0d.out_byte", i), 32'(byte1), 32'(tbl[i].byt));
                chk($sformatf("tbl%0d.out_last", i), 32'(last1), 32'(tbl[i].last));
                chk($sformatf("tbl%0d.words_sent", i), 32'(ws1), 32'(tbl[i].ws));
            end else begin
                chk($sformatf("tbl%0d.next_ready", i), 32'(nr0), 32'(tbl[i].nr));
                chk($sformatf("tbl%0d.out_valid", i), 32'(vld0), 32'(tbl[i].vld));
                chk($sformatf("tbl%0d.busy", i), 32'(busy0), 32'(tbl[i].vld));
                chk($sformatf("tbl%0d.out_byte", i), 32'(byte0), 32'(tbl[i].byt));
                chk($sformatf("tbl%0d.out_last", i), 32'(last0), 32'(tbl[i].last));
                chk($sformatf("tbl%0d.words_sent", i), 32'(ws0), 32'(tbl[i].ws));
            end
            @(posedge clk);
            #1;
        end

        // ---------------- reset in the middle of a word ----------------
        do_reset();
        buf_empty = 1'b0;
        buf_data  = 35'h6;
        @(posedge clk); #1;
        buf_empty = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.pre_valid", 32'(vld0), 32'(1));
        buf_empty = 1'b0;
        buf_data  = 35'h9;
        reset     = 1'b0;
        #1;
        chk("midrst.valid", 32'(vld0), 32'(0));
        chk("midrst.byte", 32'(byte0), 32'(0));
        chk("midrst.last", 32'(last0), 32'(0));
        chk("midrst.busy", 32'(busy0), 32'(0));
        chk("midrst.next_ready", 32'(nr0), 32'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst.pop_after", 32'(nr0), 32'(1));
        @(posedge clk); #1;
        buf_empty = 1'b1;
        @(negedge clk);
        chk("midrst.first_byte", 32'(byte0), 32'h09);
        chk("midrst.first_valid", 32'(vld0), 32'(1));
        chk("midrst.ws", 32'(ws0), 32'(0));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrst.ws_after", 32'(ws0), 32'(1));

        // ---------------- randomized run against scoreboard ----------------
        do_reset();
        bufq.delete(); expq0.delete(); expq1.delete();
        mws0 = 0; mws1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0 && bufq.size() < 4)
                bufq.push_back(35'({$urandom, $urandom}));
            buf_empty = (bufq.size() == 0);
            buf_data  = buf_empty ? 35'({$urandom, $urandom}) : bufq[0];
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            enr = !buf_empty && ((expq0.size() == 0) || (out_ready && expq0.size() == 1));
            chk("rnd.next_ready0", 32'(nr0), 32'(enr));
            chk("rnd.next_ready1", 32'(nr1), 32'(enr));
            chk("rnd.valid0", 32'(vld0), 32'(expq0.size() != 0));
            chk("rnd.valid1", 32'(vld1), 32'(expq1.size() != 0));
            chk("rnd.ws0", 32'(ws0), 32'(mws0 % 65536));
            chk("rnd.ws1", 32'(ws1), 32'(mws1 % 8));
            if (expq0.size() != 0) begin
                chk("rnd.byte0", 32'(byte0), 32'(expq0[0][7:0]));
                chk("rnd.last0", 32'(last0), 32'(expq0[0][8]));
                chk("rnd.byte1", 32'(byte1), 32'(expq1[0][7:0]));
                chk("rnd.last1", 32'(last1), 32'(expq1[0][8]));
                if (out_ready) begin
                    if (expq0[0][8]) mws0++;
                    if (expq1[0][8]) mws1++;
                    void'(expq0.pop_front());
                    void'(expq1.pop_front());
                end
            end
            if (enr) begin
                push_word(expq0, bufq[0], 1'b0);
                push_word(expq1, bufq[0], 1'b1);
                void'(bufq.pop_front());
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
